// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - shared DLX word constants, fetch FSM state type and sign-extension helper
package dlx_pkg;

    localparam int                WORD_W      = 32;
    localparam logic [WORD_W-1:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } ifu_state_t;

    function automatic logic [WORD_W-1:0] sext16to32(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry {instr, pc} queue between instruction memory and decode
// Ports: clk, rst_n (async active-low); i_push/i_data write an entry; i_pop drops the head
// (ignored when empty); i_flush empties the queue and wins over push; o_head is the oldest
// entry; o_count is the occupancy 0..2.
module fetch_fifo
    import dlx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [2*WORD_W-1:0]   i_data,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic [2*WORD_W-1:0]   o_head,
    output logic [1:0]            o_count
);

    logic [2*WORD_W-1:0] r_mem [2];
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [1:0]          r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop & (r_count != 2'd0);
    // A full queue can still take a push when the head leaves in the same cycle:
    // the write lands in the slot being vacated.
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - DLX fetch stage: PC, one-outstanding memory request FSM, redirects
// Ports: clk, rst_n (async active-low); imem_req_valid/imem_req_ready/imem_addr request
// channel; imem_rsp_valid/imem_rsp_data in-order response; instr_valid/instr/instr_pc buffer
// head to decode, consumed by dec_ready; dec_valid qualifies the redirect inputs dec_pc4,
// branch, branch_ne, jump, jump_reg, zero, boff, joff, reg_target.
module ifetch_unit
    import dlx_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                JOFF_W   = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [WORD_W-1:0] imem_rsp_data,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    input  logic              dec_ready,
    input  logic              dec_valid,
    input  logic [WORD_W-1:0] dec_pc4,
    input  logic              branch,
    input  logic              branch_ne,
    input  logic              jump,
    input  logic              jump_reg,
    input  logic              zero,
    input  logic [15:0]       boff,
    input  logic [JOFF_W-1:0] joff,
    input  logic [WORD_W-1:0] reg_target
);

    ifu_state_t          r_state;
    logic [WORD_W-1:0]   r_fetch_pc;
    logic [WORD_W-1:0]   r_inflight_pc;
    logic                r_req_valid;

    logic [WORD_W-1:0]   w_jump_target;
    logic [WORD_W-1:0]   w_branch_target;
    logic [WORD_W-1:0]   w_target;
    logic                w_branch_taken;
    logic                w_redirect;
    logic                w_accept;
    logic                w_push;
    logic                w_room_after_push;
    logic [1:0]          w_count;
    logic [2*WORD_W-1:0] w_head;

    assign w_jump_target   = dec_pc4 + {{(WORD_W-JOFF_W){joff[JOFF_W-1]}}, joff};
    assign w_branch_target = dec_pc4 + sext16to32(boff);
    assign w_branch_taken  = (branch & zero) | (branch_ne & ~zero);
    assign w_redirect      = dec_valid & (jump_reg | jump | w_branch_taken);

    always_comb begin
        if (jump_reg) begin
            w_target = reg_target;
        end else if (jump) begin
            w_target = w_jump_target;
        end else begin
            w_target = w_branch_target;
        end
        w_target[1:0] = 2'b00;
    end

    assign w_accept = (r_state == REQ) & imem_req_ready;
    assign w_push   = (r_state == WAIT) & imem_rsp_valid;
    // Space left once the arriving word is written, counting a same-cycle pop.
    assign w_room_after_push = (w_count == 2'd0) | ((w_count == 2'd1) & dec_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_req_valid   <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= '0;
        end else begin
            if (w_accept) begin
                r_inflight_pc <= r_fetch_pc;
            end
            if (w_redirect) begin
                r_fetch_pc <= w_target;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + INSTR_BYTES;
            end

            case (r_state)
                IDLE: begin
                    // Nothing is outstanding here, so only buffer occupancy gates a request.
                    if (w_redirect || (w_count != 2'd2)) begin
                        r_state     <= REQ;
                        r_req_valid <= 1'b1;
                    end
                end
                REQ: begin
                    // An accepted address is already in flight; a redirect must discard it.
                    if (w_accept) begin
                        r_state     <= w_redirect ? DROP : WAIT;
                        r_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (w_redirect || w_room_after_push) begin
                            r_state     <= REQ;
                            r_req_valid <= 1'b1;
                        end else begin
                            r_state     <= IDLE;
                            r_req_valid <= 1'b0;
                        end
                    end else if (w_redirect) begin
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    // The stale word is discarded whether or not a new redirect arrives with it.
                    if (imem_rsp_valid) begin
                        r_state     <= REQ;
                        r_req_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo u_fetch_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({imem_rsp_data, r_inflight_pc}),
        .i_pop   (dec_ready),
        .i_flush (w_redirect),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign imem_req_valid = r_req_valid;
    assign imem_addr      = r_fetch_pc;
    assign instr_valid    = (w_count != 2'd0);
    assign instr          = w_head[2*WORD_W-1:WORD_W];
    assign instr_pc       = w_head[WORD_W-1:0];

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit with a program-order fetch model
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          JW       = 26;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [31:0]   imem_addr;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic          dec_ready;
    logic          dec_valid;
    logic [31:0]   dec_pc4;
    logic          branch;
    logic          branch_ne;
    logic          jump;
    logic          jump_reg;
    logic          zero;
    logic [15:0]   boff;
    logic [JW-1:0] joff;
    logic [31:0]   reg_target;

    ifetch_unit #(.RESET_PC(RESET_PC), .JOFF_W(JW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .dec_ready      (dec_ready),
        .dec_valid      (dec_valid),
        .dec_pc4        (dec_pc4),
        .branch         (branch),
        .branch_ne      (branch_ne),
        .jump           (jump),
        .jump_reg       (jump_reg),
        .zero           (zero),
        .boff           (boff),
        .joff           (joff),
        .reg_target     (reg_target)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_cons  = 0;
    int          n_acc   = 0;
    logic [63:0] exp_q[$];      // expected {instr, pc} in delivery order
    logic [31:0] req_q[$];      // expected address of the next accepted request
    logic [31:0] exp_req_pc;
    logic [31:0] infl_pc;
    logic [31:0] mem_addr;
    int          epoch      = 0;
    int          infl_epoch = -1;
    bit          mem_pending = 1'b0;
    int          mem_delay  = 0;
    int          lat_min    = 0;
    int          lat_max    = 0;
    bit          last_acc   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string msg);
        n_tests++;
        n_fail++;
        $display("FAIL %s", msg);
    endtask

    // Fetch target straight from the instruction semantics, in signed integer arithmetic.
    function automatic logic [31:0] model_target();
        longint t;
        longint off;
        logic [63:0] m;
        if (jump_reg) begin
            t = longint'(reg_target);
        end else if (jump) begin
            off = longint'(joff);
            if (joff[JW-1]) off = off - (longint'(1) << JW);
            t = longint'(dec_pc4) + off;
        end else begin
            off = longint'(boff);
            if (boff[15]) off = off - 65536;
            t = longint'(dec_pc4) + off;
        end
        m = 64'(t) & 64'h0000_0000_FFFF_FFFC;
        return m[31:0];
    endfunction

    function automatic bit model_redirect();
        return dec_valid && (jump_reg || jump || (branch && zero) || (branch_ne && !zero));
    endfunction

    task automatic model_reset();
        exp_q.delete();
        req_q.delete();
        exp_req_pc = RESET_PC;
        req_q.push_back(RESET_PC);
        epoch++;
        mem_pending = 1'b0;
    endtask

    // Runs between the falling and rising edge: applies what the coming edge will do.
    task automatic model_update();
        last_acc = 1'b0;
        if (imem_rsp_valid && infl_epoch == epoch)
            exp_q.push_back({infl_pc + 32'd1, infl_pc});
        if (imem_req_valid && imem_req_ready) begin
            last_acc    = 1'b1;
            n_acc++;
            infl_pc     = exp_req_pc;
            infl_epoch  = epoch;
            mem_pending = 1'b1;
            mem_addr    = imem_addr;
            mem_delay   = $urandom_range(lat_max, lat_min);
            exp_req_pc  = exp_req_pc + 32'd4;
            req_q.push_back(exp_req_pc);
        end
        if (model_redirect()) begin
            exp_q.delete();
            epoch++;
            exp_req_pc = model_target();
            req_q.delete();
            req_q.push_back(exp_req_pc);
        end
    endtask

    task automatic mem_drive();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mem_pending) begin
            if (mem_delay == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_addr + 32'd1;
                mem_pending    = 1'b0;
            end else begin
                mem_delay--;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        model_update();
        @(posedge clk);
        #1;
        mem_drive();
    endtask

    task automatic idle_inputs();
        dec_valid  = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        jump       = 1'b0;
        jump_reg   = 1'b0;
        zero       = 1'b0;
        boff       = '0;
        joff       = '0;
        dec_pc4    = '0;
        reg_target = '0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        mem_pending    = 1'b0;
        #1;
        chk("async_reset_req_valid", 32'(imem_req_valid), 32'd0);
        chk("async_reset_instr_valid", 32'(instr_valid), 32'd0);
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_acc(input string name);
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_acc) return;
        end
        fail($sformatf("%s: got no accepted request in 20 cycles, expected one", name));
    endtask

    // Monitor: compares the buffer head and accepted request addresses against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    fail($sformatf("unexpected_instr: got pc=%h instr=%h, expected no valid head",
                                   instr_pc, instr));
                end else begin
                    chk("instr_pc", instr_pc, exp_q[0][31:0]);
                    chk("instr", instr, exp_q[0][63:32]);
                    if (dec_ready) begin
                        void'(exp_q.pop_front());
                        n_cons++;
                    end
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                if (req_q.size() == 0) begin
                    fail($sformatf("unexpected_req: got addr=%h, expected no request", imem_addr));
                end else begin
                    chk("imem_addr", imem_addr, req_q[0]);
                    void'(req_q.pop_front());
                end
            end
        end
    end

    int c0;
    int a0;

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        dec_ready      = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
        chk("reset_instr_valid", 32'(instr_valid), 32'd0);
        chk("reset_instr", instr, 32'd0);
        chk("reset_instr_pc", instr_pc, 32'd0);
        rst_n = 1'b1;
        model_reset();

        // Sequential streaming, one-cycle memory: requests 0,4,8,... one every two cycles.
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        c0 = n_cons;
        a0 = n_acc;
        repeat (20) step();
        chk("stream_request_count", 32'(n_acc - a0), 32'd10);
        chk("stream_delivered_ge3", 32'(n_cons - c0 >= 3), 32'd1);

        // Decode stalled: the buffer fills and requests stop, then resume at 8.
        do_reset(2);
        dec_ready = 1'b0;
        repeat (12) step();
        for (int i = 0; i < 4; i++) begin
            chk("full_req_valid", 32'(imem_req_valid), 32'd0);
            chk("full_instr_valid", 32'(instr_valid), 32'd1);
            step();
        end
        dec_ready = 1'b1;
        repeat (10) step();

        // Taken BEQZ-style branch, then the same stimulus as a not-taken BNEZ.
        dec_valid = 1'b1; branch = 1'b1; zero = 1'b1; dec_pc4 = 32'h100; boff = 16'hFFF0;
        step();
        idle_inputs();
        chk("branch_flush_instr_valid", 32'(instr_valid), 32'd0);
        repeat (8) step();
        dec_valid = 1'b1; branch_ne = 1'b1; zero = 1'b1; dec_pc4 = 32'h100; boff = 16'hFFF0;
        step();
        idle_inputs();
        repeat (8) step();

        // Register jump while a response is outstanding: that response must vanish.
        lat_min = 2;
        lat_max = 2;
        wait_acc("wait_state_entry");
        dec_valid = 1'b1; jump_reg = 1'b1; reg_target = 32'h2000;
        step();
        idle_inputs();
        chk("jr_flush_instr_valid", 32'(instr_valid), 32'd0);
        repeat (14) step();
        lat_min = 0;
        lat_max = 0;

        // jump_reg outranks jump.
        dec_valid = 1'b1; jump = 1'b1; jump_reg = 1'b1; joff = 26'd8;
        dec_pc4 = 32'h40; reg_target = 32'h900;
        step();
        idle_inputs();
        repeat (10) step();

        // Sequential wrap at the top of the address space, unaligned target masked.
        dec_valid = 1'b1; jump_reg = 1'b1; reg_target = 32'hFFFF_FFFB;
        step();
        idle_inputs();
        repeat (12) step();

        // Stall in REQ, then reset mid-stream; fetch restarts at RESET_PC.
        imem_req_ready = 1'b0;
        repeat (4) step();
        chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
        do_reset(2);
        imem_req_ready = 1'b1;
        repeat (10) step();

        // Randomised traffic, latencies, redirects and occasional resets.
        lat_min = 0;
        lat_max = 3;
        c0 = n_cons;
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom_range(99, 0) < 60);
            dec_ready      = ($urandom_range(99, 0) < 70);
            dec_valid      = ($urandom_range(99, 0) < 12);
            branch         = 1'($urandom_range(1, 0));
            branch_ne      = 1'($urandom_range(1, 0));
            jump           = ($urandom_range(3, 0) == 0);
            jump_reg       = ($urandom_range(3, 0) == 0);
            zero           = 1'($urandom_range(1, 0));
            boff           = 16'($urandom);
            joff           = JW'($urandom);
            dec_pc4        = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 : $urandom;
            reg_target     = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF4 | 32'($urandom_range(3, 0)))
                                                         : $urandom;
            if ($urandom_range(799, 0) == 0) do_reset(2);
            step();
        end
        idle_inputs();
        chk("random_delivered_gt100", 32'(n_cons - c0 > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
